// File: rtl/seg_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_capture
//  Description : Samples a multiplexed 4-digit 7-segment display bus, decodes
//                the segments back to BCD and reports complete frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_capture #(
    parameter int STABLE_CYC  = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       dp_in,
    input  logic [3:0] dig_en,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic [3:0] dp_mask,
    output logic       frame_valid,
    output logic       frame_changed,
    output logic       seg_err,
    output logic       sel_err,
    output logic       stale
);

    localparam logic [3:0]  c_stable  = 4'(STABLE_CYC);
    localparam logic [3:0]  c_sat     = 4'd15;
    localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYC);
    localparam logic [15:0] c_to_max  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_WAIT1 = 2'd0,
        S_GOT1  = 2'd1,
        S_GOT2  = 2'd2,
        S_GOT3  = 2'd3
    } state_t;

    // Returns {legal, bcd}
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b1111110: res = {1'b1, 4'd0};
            7'b0110000: res = {1'b1, 4'd1};
            7'b1101101: res = {1'b1, 4'd2};
            7'b1111001: res = {1'b1, 4'd3};
            7'b0110011: res = {1'b1, 4'd4};
            7'b1011011: res = {1'b1, 4'd5};
            7'b0011111: res = {1'b1, 4'd6};
            7'b1110000: res = {1'b1, 4'd7};
            7'b1111111: res = {1'b1, 4'd8};
            7'b1110011: res = {1'b1, 4'd9};
            default:    res = 5'd0;
        endcase
        return res;
    endfunction

    // Sample layout: {dig_en[3:0], seg[6:0], dp}
    logic [11:0] r_smp;
    logic [11:0] r_prev;
    logic [3:0]  r_stab;
    logic        r_acc;
    logic [11:0] r_acc_smp;

    logic        w_changed;
    logic [3:0]  w_stab_next;
    logic        w_accept;

    assign w_changed   = (r_smp != r_prev);
    assign w_stab_next = w_changed ? 4'd1 :
                         (r_stab == c_sat) ? c_sat : (r_stab + 4'd1);
    // The saturated case must not re-fire when STABLE_CYC is at the ceiling.
    assign w_accept    = (w_stab_next == c_stable) &&
                         (w_changed || (r_stab != c_stable));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp     <= 12'd0;
            r_prev    <= 12'd0;
            r_stab    <= 4'd0;
            r_acc     <= 1'b0;
            r_acc_smp <= 12'd0;
        end else begin
            r_smp     <= {dig_en, seg_in, dp_in};
            r_prev    <= r_smp;
            r_stab    <= w_stab_next;
            r_acc     <= w_accept;
            r_acc_smp <= r_smp;
        end
    end

    logic [3:0] w_acc_en;
    logic [6:0] w_acc_seg;
    logic       w_acc_dp;
    logic [4:0] w_dec;
    logic       w_multi;
    logic       w_blank;
    logic [1:0] w_idx;

    assign w_acc_en  = r_acc_smp[11:8];
    assign w_acc_seg = r_acc_smp[7:1];
    assign w_acc_dp  = r_acc_smp[0];
    assign w_dec     = f_decode(w_acc_seg);
    assign w_multi   = |(w_acc_en & (w_acc_en - 4'd1));
    assign w_blank   = (w_acc_en == 4'd0);

    always_comb begin
        w_idx = 2'd0;
        case (w_acc_en)
            4'b0001: w_idx = 2'd0;
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    state_t      r_state;
    logic [3:0]  r_sh_dig [3];
    logic [2:0]  r_sh_dp;
    logic        r_seen;
    logic [15:0] r_to_cnt;

    logic        w_frame_done;
    logic [19:0] w_frame_new;
    logic [19:0] w_frame_old;
    logic [15:0] w_to_next;

    assign w_frame_done = r_acc && !w_blank && !w_multi && w_dec[4] &&
                          (w_idx == 2'd3) && (r_state == S_GOT3);
    assign w_frame_new  = {r_sh_dig[0], r_sh_dig[1], r_sh_dig[2], w_dec[3:0],
                           w_acc_dp, r_sh_dp};
    assign w_frame_old  = {digit1, digit2, digit3, digit4, dp_mask};
    assign w_to_next    = (r_to_cnt == c_to_max) ? r_to_cnt : (r_to_cnt + 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_WAIT1;
            r_sh_dig      <= '{default: 4'd0};
            r_sh_dp       <= 3'd0;
            r_seen        <= 1'b0;
            r_to_cnt      <= 16'd0;
            digit1        <= 4'd0;
            digit2        <= 4'd0;
            digit3        <= 4'd0;
            digit4        <= 4'd0;
            dp_mask       <= 4'd0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            seg_err       <= 1'b0;
            sel_err       <= 1'b0;
            stale         <= 1'b0;
        end else begin
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            seg_err       <= 1'b0;
            sel_err       <= 1'b0;

            if (w_frame_done) begin
                r_to_cnt <= 16'd0;
                stale    <= 1'b0;
            end else begin
                r_to_cnt <= w_to_next;
                stale    <= (w_to_next >= c_timeout);
            end

            // Errors are checked before ordering so they pre-empt a restart.
            if (r_acc && !w_blank) begin
                if (w_multi) begin
                    sel_err <= 1'b1;
                    r_state <= S_WAIT1;
                end else if (!w_dec[4]) begin
                    seg_err <= 1'b1;
                    r_state <= S_WAIT1;
                end else if (w_idx == r_state) begin
                    if (r_state == S_GOT3) begin
                        digit1        <= r_sh_dig[0];
                        digit2        <= r_sh_dig[1];
                        digit3        <= r_sh_dig[2];
                        digit4        <= w_dec[3:0];
                        dp_mask       <= {w_acc_dp, r_sh_dp};
                        frame_valid   <= 1'b1;
                        frame_changed <= !r_seen || (w_frame_new != w_frame_old);
                        r_seen        <= 1'b1;
                        r_state       <= S_WAIT1;
                    end else begin
                        r_sh_dig[w_idx] <= w_dec[3:0];
                        r_sh_dp[w_idx]  <= w_acc_dp;
                        r_state         <= state_t'(r_state + 2'd1);
                    end
                end else if (w_idx == 2'd0) begin
                    r_sh_dig[0] <= w_dec[3:0];
                    r_sh_dp[0]  <= w_acc_dp;
                    r_state     <= S_GOT1;
                end else begin
                    r_state <= S_WAIT1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_capture
//  Description : Scoreboard bench for seg_scan_capture; two instances with
//                different stability filters share one stimulus stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_capture;

    localparam int c_to = 16;

    function automatic int f_stab(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_in = 7'd0;
    logic       dp_in = 1'b0;
    logic [3:0] dig_en = 4'd0;

    logic [3:0] dg1 [2];
    logic [3:0] dg2 [2];
    logic [3:0] dg3 [2];
    logic [3:0] dg4 [2];
    logic [3:0] dpm [2];
    logic       fv [2];
    logic       fc [2];
    logic       se [2];
    logic       le [2];
    logic       st [2];

    seg_scan_capture #(.STABLE_CYC(1), .TIMEOUT_CYC(c_to)) u_dut_s1 (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dp_in(dp_in), .dig_en(dig_en),
        .digit1(dg1[0]), .digit2(dg2[0]), .digit3(dg3[0]), .digit4(dg4[0]),
        .dp_mask(dpm[0]), .frame_valid(fv[0]), .frame_changed(fc[0]),
        .seg_err(se[0]), .sel_err(le[0]), .stale(st[0])
    );

    seg_scan_capture #(.STABLE_CYC(3), .TIMEOUT_CYC(c_to)) u_dut_s3 (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dp_in(dp_in), .dig_en(dig_en),
        .digit1(dg1[1]), .digit2(dg2[1]), .digit3(dg3[1]), .digit4(dg4[1]),
        .dp_mask(dpm[1]), .frame_valid(fv[1]), .frame_changed(fc[1]),
        .seg_err(se[1]), .sel_err(le[1]), .stale(st[1])
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int          at;
        logic [15:0] dig;
        logic [3:0]  dp;
        logic        chg;
    } frm_t;

    typedef struct {
        int   at;
        logic sel;
    } err_t;

    frm_t q_frm [2][$];
    err_t q_err [2][$];

    logic [6:0] seg_tab [10];

    // Reference model state
    logic [11:0] m_last [2];
    int          m_run [2];
    int          m_st [2];
    logic [3:0]  m_dig [2][4];
    logic [3:0]  m_dp [2];
    logic [15:0] m_prev_dig [2];
    logic [3:0]  m_prev_dp [2];
    bit          m_first [2];

    // Expected held outputs, as seen by the monitor
    logic [15:0] h_dig [2];
    logic [3:0]  h_dp [2];
    int          h_base [2];
    bit          checking = 1'b0;

    int errors = 0;
    int checks = 0;

    function automatic int f_val(input logic [6:0] s);
        for (int i = 0; i < 10; i++)
            if (seg_tab[i] == s) return i;
        return -1;
    endfunction

    function automatic int f_pos(input logic [3:0] en);
        for (int i = 0; i < 4; i++)
            if (en[i]) return i;
        return 0;
    endfunction

    task automatic model(input int d, input int e, input logic [3:0] en,
                         input logic [6:0] sg, input logic p);
        logic [11:0] v;
        int          val;
        int          idx;
        frm_t        f;
        err_t        er;
        v = {en, sg, p};
        if (v == m_last[d]) m_run[d]++;
        else m_run[d] = 1;
        m_last[d] = v;
        if (m_run[d] != f_stab(d) || en == 4'd0) return;
        if ($countones(en) > 1) begin
            er.at = e + 2; er.sel = 1'b1;
            q_err[d].push_back(er);
            m_st[d] = 0;
            return;
        end
        val = f_val(sg);
        if (val < 0) begin
            er.at = e + 2; er.sel = 1'b0;
            q_err[d].push_back(er);
            m_st[d] = 0;
            return;
        end
        idx = f_pos(en);
        if (idx == m_st[d] || idx == 0) begin
            m_dig[d][idx] = val[3:0];
            m_dp[d][idx]  = p;
            if (idx == 3) begin
                f.at  = e + 2;
                f.dig = {m_dig[d][0], m_dig[d][1], m_dig[d][2], m_dig[d][3]};
                f.dp  = m_dp[d];
                f.chg = m_first[d] || (f.dig != m_prev_dig[d]) || (f.dp != m_prev_dp[d]);
                m_prev_dig[d] = f.dig;
                m_prev_dp[d]  = f.dp;
                m_first[d]    = 1'b0;
                q_frm[d].push_back(f);
                m_st[d] = 0;
            end else begin
                m_st[d] = idx + 1;
            end
        end else begin
            m_st[d] = 0;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_last[d] = 12'd0;
            m_run[d] = 1;
            m_st[d] = 0;
            m_dp[d] = 4'd0;
            m_prev_dig[d] = 16'd0;
            m_prev_dp[d] = 4'd0;
            m_first[d] = 1'b1;
            q_frm[d].delete();
            q_err[d].delete();
            h_dig[d] = 16'd0;
            h_dp[d] = 4'd0;
            h_base[d] = edge_n;
        end
    endtask

    task automatic step(input logic [3:0] en, input logic [6:0] sg,
                        input logic p, input int hold);
        for (int i = 0; i < hold; i++) begin
            dig_en = en; seg_in = sg; dp_in = p;
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) model(d, edge_n, en, sg, p);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; dig_en = 4'd0; seg_in = 7'd0; dp_in = 1'b0;
        @(posedge clk); #1;
        checking = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        checking = 1'b1;
    endtask

    task automatic scan(input int v1, input int v2, input int v3, input int v4,
                        input logic [3:0] dpv, input int hold);
        step(4'b0001, seg_tab[v1], dpv[0], hold);
        step(4'b0010, seg_tab[v2], dpv[1], hold);
        step(4'b0100, seg_tab[v3], dpv[2], hold);
        step(4'b1000, seg_tab[v4], dpv[3], hold);
    endtask

    task automatic mon(input int d);
        frm_t f;
        err_t er;
        logic exp_st;
        while (q_frm[d].size() > 0 && q_frm[d][0].at < edge_n) begin
            checks++; errors++;
            $display("FAIL dut%0d frame_missing: no frame_valid pulse, required frame at edge %0d", d, q_frm[d][0].at);
            f = q_frm[d].pop_front();
        end
        while (q_err[d].size() > 0 && q_err[d][0].at < edge_n) begin
            checks++; errors++;
            $display("FAIL dut%0d err_missing: no error pulse, required sel=%0b at edge %0d", d, q_err[d][0].sel, q_err[d][0].at);
            er = q_err[d].pop_front();
        end
        checks++;
        if (fv[d]) begin
            if (q_frm[d].size() == 0) begin
                errors++;
                $display("FAIL dut%0d frame_unexpected: frame_valid at edge %0d, none required", d, edge_n);
            end else begin
                f = q_frm[d].pop_front();
                if (f.at != edge_n || {dg1[d], dg2[d], dg3[d], dg4[d]} != f.dig ||
                    dpm[d] != f.dp || fc[d] != f.chg) begin
                    errors++;
                    $display("FAIL dut%0d frame: got edge %0d dig %h dp %b chg %b, required edge %0d dig %h dp %b chg %b",
                             d, edge_n, {dg1[d], dg2[d], dg3[d], dg4[d]}, dpm[d], fc[d], f.at, f.dig, f.dp, f.chg);
                end
                h_dig[d] = f.dig;
                h_dp[d] = f.dp;
                h_base[d] = f.at;
            end
        end else if (fc[d]) begin
            errors++;
            $display("FAIL dut%0d changed_alone: frame_changed=1 without frame_valid at edge %0d, required 0", d, edge_n);
        end
        checks++;
        if (se[d] || le[d]) begin
            if (q_err[d].size() == 0) begin
                errors++;
                $display("FAIL dut%0d err_unexpected: seg_err=%0b sel_err=%0b at edge %0d, required 0", d, se[d], le[d], edge_n);
            end else begin
                er = q_err[d].pop_front();
                if (er.at != edge_n || le[d] != er.sel || se[d] != !er.sel) begin
                    errors++;
                    $display("FAIL dut%0d err: got edge %0d seg_err %0b sel_err %0b, required edge %0d sel %0b",
                             d, edge_n, se[d], le[d], er.at, er.sel);
                end
            end
        end
        checks++;
        if ({dg1[d], dg2[d], dg3[d], dg4[d]} != h_dig[d] || dpm[d] != h_dp[d]) begin
            errors++;
            $display("FAIL dut%0d hold: got dig %h dp %b, required dig %h dp %b at edge %0d",
                     d, {dg1[d], dg2[d], dg3[d], dg4[d]}, dpm[d], h_dig[d], h_dp[d], edge_n);
        end
        exp_st = ((edge_n - h_base[d]) >= c_to);
        checks++;
        if (st[d] != exp_st) begin
            errors++;
            $display("FAIL dut%0d stale: got %0b, required %0b at edge %0d", d, st[d], exp_st, edge_n);
        end
    endtask

    always @(negedge clk) begin
        if (checking)
            for (int d = 0; d < 2; d++) mon(d);
    end

    initial begin
        logic [3:0] en;
        logic [6:0] sg;
        int         pos;
        int         r;
        seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                    7'b1011011, 7'b0011111, 7'b1110000, 7'b1111111, 7'b1110011};
        do_reset();
        step(4'd0, 7'd0, 1'b0, 3);

        // Basic frame then an identical repeat
        scan(1, 2, 3, 4, 4'b0010, 1);
        step(4'd0, 7'd0, 1'b0, 3);
        scan(1, 2, 3, 4, 4'b0010, 1);
        step(4'd0, 7'd0, 1'b0, 3);

        // Every legal pattern on every position
        for (int v = 0; v < 10; v++)
            scan(v, (v + 1) % 10, (v + 2) % 10, (v + 3) % 10, 4'(v), (v < 3) ? 3 : 1);

        // Illegal pattern on digit 3
        step(4'b0001, seg_tab[5], 1'b0, 1);
        step(4'b0010, seg_tab[6], 1'b0, 1);
        step(4'b0100, 7'b0000001, 1'b0, 1);
        step(4'b1000, seg_tab[7], 1'b0, 1);
        step(4'd0, 7'd0, 1'b0, 3);

        // Ordering: skip, then good, then restart mid-frame
        step(4'b0001, seg_tab[1], 1'b0, 1);
        step(4'b0010, seg_tab[2], 1'b0, 1);
        step(4'b1000, seg_tab[4], 1'b0, 1);
        scan(1, 2, 3, 4, 4'b0000, 1);
        step(4'b0001, seg_tab[9], 1'b0, 1);
        step(4'b0010, seg_tab[8], 1'b0, 1);
        scan(7, 8, 6, 5, 4'b0100, 1);

        // Multi-hot select, then a frame with blanks between digits
        step(4'b0011, seg_tab[1], 1'b0, 3);
        step(4'b0001, seg_tab[0], 1'b1, 3);
        step(4'b0000, 7'd0, 1'b0, 2);
        step(4'b0010, seg_tab[3], 1'b0, 3);
        step(4'b0000, seg_tab[3], 1'b0, 1);
        step(4'b0100, seg_tab[9], 1'b0, 3);
        step(4'b1000, seg_tab[2], 1'b1, 3);

        // Short glitch on digit 2 for the slow filter
        step(4'b0001, seg_tab[3], 1'b0, 3);
        step(4'b0010, seg_tab[4], 1'b0, 2);
        step(4'b0100, seg_tab[5], 1'b0, 3);
        step(4'b1000, seg_tab[6], 1'b0, 3);
        scan(2, 4, 6, 8, 4'b1001, 3);

        // Idle into stale, then recover
        step(4'd0, 7'd0, 1'b0, 40);
        scan(3, 1, 4, 1, 4'b0000, 3);

        // Reset after digit 2
        step(4'b0001, seg_tab[9], 1'b0, 3);
        step(4'b0010, seg_tab[9], 1'b0, 3);
        do_reset();
        step(4'b0100, seg_tab[1], 1'b0, 3);
        step(4'b1000, seg_tab[1], 1'b0, 3);
        scan(5, 6, 7, 8, 4'b0000, 3);

        // Randomised scanning with faults mixed in
        pos = 0;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            sg = seg_tab[$urandom_range(0, 9)];
            if (r < 14) begin
                if (r >= 11) pos = $urandom_range(0, 3);
                en = 4'b0001 << pos;
                pos = (pos + 1) % 4;
            end else if (r < 16) begin
                en = 4'd0;
            end else if (r == 16) begin
                en = 4'($urandom_range(3, 15));
                if ($countones(en) < 2) en = 4'b1100;
            end else begin
                en = 4'b0001 << pos;
                pos = (pos + 1) % 4;
                if (r == 17) sg = 7'($urandom_range(0, 127));
            end
            step(en, sg, 1'($urandom_range(0, 1)), $urandom_range(1, 4));
        end
        step(4'd0, 7'd0, 1'b0, 6);

        for (int d = 0; d < 2; d++) begin
            checks++;
            if (q_frm[d].size() != 0 || q_err[d].size() != 0) begin
                errors++;
                $display("FAIL dut%0d leftover: %0d frames %0d errors pending, required 0",
                         d, q_frm[d].size(), q_err[d].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the stopwatch's multiplexed 4-digit 7-segment display driver.
- Samples the segment lines, the decimal-point line and the digit enables, then decodes the segments back to BCD.
- Assembles complete 4-digit frames and reports them with a valid strobe.
- Used as a display-bus monitor and for readback/self-check of the stopwatch value.

Parameters:
- STABLE_CYC, 1, consecutive identical registered samples required before a digit is accepted (1..15).
- TIMEOUT_CYC, 1024, cycles without a completed frame before `stale` asserts (width 16 bits internally).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- seg_in  input  7  segments {a,b,c,d,e,f,g}; a is the MSB; 1 = segment lit
- dp_in  input  1  decimal point (h)
- dig_en  input  4  one-hot digit enable; bit0 = digit 1 (most significant, leftmost) ... bit3 = digit 4
- digit1..digit4  output  4 each  captured BCD digits
- dp_mask  output  4  captured dp per digit; bit i = digit i+1
- frame_valid  output  1  1-cycle pulse: new complete frame on outputs
- frame_changed  output  1  1-cycle pulse coincident with frame_valid when the frame differs from the previous one
- seg_err  output  1  1-cycle pulse: accepted segment pattern is not a legal digit
- sel_err  output  1  1-cycle pulse: dig_en is multi-hot
- stale  output  1  level: no frame completed within TIMEOUT_CYC cycles

Behaviour:
- Reset (rst=1 at a clk edge):
  - all outputs 0, digits 0, dp_mask 0;
  - input register, stability counter and timeout counter cleared;
  - FSM set to WAIT1.
  - Reset mid-frame discards the partial frame.
- Input stage: seg_in, dp_in and dig_en are registered every edge. All decisions use the registered sample.
- Stability:
  - The counter increments while the registered {dig_en, seg, dp} equals the previous sample, saturating at 15.
  - It reloads to 1 on any change.
  - A digit is accepted exactly once per hold, on the cycle the counter reaches STABLE_CYC. Holding longer never re-accepts.
- Selection rules:
  - dig_en = 0000: blank, ignored, FSM unchanged.
  - Multi-hot dig_en at acceptance: sel_err pulse, FSM → WAIT1.
- Decode table (abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=0011111, 7=1110000, 8=1111111, 9=1110011
  - Any other pattern: seg_err pulse, FSM → WAIT1.
- FSM states WAIT1, GOT1, GOT2, GOT3. The expected digit is the state index + 1.
  - Accepted digit equals the expected digit: store its BCD value and dp into a shadow register, advance one state.
  - Digit 4 accepted in GOT3: copy the shadow to digit1..4 and dp_mask, pulse frame_valid, return to WAIT1.
  - Accepted digit 1 in any state: restart, store it, go to GOT1.
  - Any other out-of-order digit: drop the frame, go to WAIT1.
  - An error takes priority over a restart on the same accept.
- Outputs update only on frame_valid. Otherwise they hold.
- Latency: if digit 4 is stable at the inputs from edge k through edge k+STABLE_CYC−1, then frame_valid is high for exactly the cycle following edge k+STABLE_CYC+1.
  - For STABLE_CYC=1, the input is sampled at edge k and frame_valid is high after edge k+2.
- frame_changed:
  - pulses with frame_valid when {digits, dp_mask} differ from the values held before the update;
  - the first frame after reset always asserts frame_changed.
- Timeout:
  - the counter clears on frame_valid, otherwise increments, saturating;
  - stale = 1 once the count reaches TIMEOUT_CYC;
  - stale clears on the same edge that asserts frame_valid.

Test Plan:
- Scan digits 1→2→3→4 carrying 1,2,3,4, with dp only on digit 2, one per cycle, STABLE_CYC=1 → digits=1,2,3,4, dp_mask=0010, frame_valid one pulse 2 edges after digit 4 is sampled, frame_changed=1. Repeat the identical scan → frame_valid=1, frame_changed=0.
- Sweep every legal pattern 0–9 on all four positions → each digit reads back 0..9. Inject 0000001 on digit 3 → seg_err pulse, no frame_valid, outputs unchanged.
- Drive order 1,2,4 → no frame. Then 1,2,3,4 → frame_valid. Drive order 1,2,1,2,3,4 → one frame, with digit 1 taken from the second occurrence.
- dig_en=0011 → sel_err pulse, FSM in WAIT1. dig_en=0000 between digits → ignored; the frame still completes.
- STABLE_CYC=3: a 2-cycle glitch on digit 2 is not accepted. Hold each digit 3+ cycles → frame completes, with latency STABLE_CYC+1 edges after digit 4 is presented.
- TIMEOUT_CYC=16, inputs idle → stale=1 at count 16; a subsequent valid frame clears it. Assert rst after digit 2 → outputs 0 and the next frame must start from digit 1.
